// File: rtl/pwm_encoder.sv
// PWM encoder: a duty value taken over valid/ready lands in a shadow register
// and becomes the active duty only at a period boundary, so periods never glitch.
module pwm_encoder #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter bit POLARITY = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic             enable,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0]   PRE_LAST  = PCW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PCNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PCW-1:0]   r_pre_cnt;
  logic [PCW-1:0]   w_pre_cnt_nxt;
  logic [WIDTH-1:0] r_pcnt;
  logic [WIDTH-1:0] w_pcnt_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_shadow_full;
  logic [WIDTH-1:0] r_duty_active;
  logic             r_period_start;
  logic             w_period_start_nxt;
  logic             r_pwm;
  logic             w_pwm_nxt;
  logic             w_tick;
  logic             w_load;
  logic             w_accept;

  // Handshake: a transfer happens on a rising clk edge where duty_valid and
  // duty_ready are both high; the sender must hold duty_in until then.
  assign duty_ready   = !r_shadow_full;
  assign w_accept     = duty_valid && !r_shadow_full;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign duty_active  = r_duty_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pre_cnt_nxt      = '0;
    w_pcnt_nxt         = '0;
    w_period_start_nxt = 1'b0;
    w_pwm_nxt          = POLARITY;
    w_tick             = 1'b0;
    w_load             = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt        = ST_RUN;
          w_period_start_nxt = 1'b1;
          w_load             = r_shadow_full;
        end
      end
      ST_RUN: begin
        // Dropping enable beats any boundary in the same cycle.
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_pwm_nxt     = (r_pcnt < r_duty_active) ^ POLARITY;
          w_tick        = (r_pre_cnt == PRE_LAST);
          w_pre_cnt_nxt = w_tick ? '0 : r_pre_cnt + PCW'(1);
          w_pcnt_nxt    = r_pcnt;
          if (w_tick) begin
            if (r_pcnt == PCNT_LAST) begin
              w_pcnt_nxt         = '0;
              w_period_start_nxt = 1'b1;
              w_load             = r_shadow_full;
            end else begin
              w_pcnt_nxt = r_pcnt + WIDTH'(1);
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_cnt      <= '0;
      r_pcnt         <= '0;
      r_period_start <= 1'b0;
      r_pwm          <= POLARITY;
    end else begin
      r_pre_cnt      <= w_pre_cnt_nxt;
      r_pcnt         <= w_pcnt_nxt;
      r_period_start <= w_period_start_nxt;
      r_pwm          <= w_pwm_nxt;
    end
  end

  // A load needs a full shadow, which keeps duty_ready low, so load and
  // accept can never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_duty_active <= '0;
    end else begin
      if (w_load) begin
        r_duty_active <= r_shadow;
        r_shadow_full <= 1'b0;
      end else if (w_accept) begin
        r_shadow      <= duty_in;
        r_shadow_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_encoder.sv
// Directed bench for pwm_encoder: default instance (PRESCALE=1, POLARITY=0)
// and an inverted, prescaled instance (PRESCALE=4, POLARITY=1).
module tb_pwm_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] a_duty_in;
  logic       a_duty_valid;
  logic       a_duty_ready;
  logic       a_enable;
  logic       a_pwm;
  logic       a_ps;
  logic [7:0] a_duty_active;
  logic [7:0] b_duty_in;
  logic       b_duty_valid;
  logic       b_duty_ready;
  logic       b_enable;
  logic       b_pwm;
  logic       b_ps;
  logic [7:0] b_duty_active;

  int n_cmp;
  int n_err;

  pwm_encoder #(.WIDTH(8), .PRESCALE(1), .POLARITY(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .duty_in(a_duty_in), .duty_valid(a_duty_valid),
    .duty_ready(a_duty_ready), .enable(a_enable), .pwm_out(a_pwm),
    .period_start(a_ps), .duty_active(a_duty_active)
  );

  pwm_encoder #(.WIDTH(8), .PRESCALE(4), .POLARITY(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .duty_in(b_duty_in), .duty_valid(b_duty_valid),
    .duty_ready(b_duty_ready), .enable(b_enable), .pwm_out(b_pwm),
    .period_start(b_ps), .duty_active(b_duty_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until period_start on instance A; n is the number of cycles taken.
  task automatic wait_ps_a(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!a_ps && n < 2000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++; if (a_duty_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0d want 1", a_duty_ready); end
    n_cmp++; if (a_duty_active !== 8'd0) begin n_err++; $display("FAIL rst_duty: got %0d want 0", a_duty_active); end
    n_cmp++; if (a_ps !== 1'b0) begin n_err++; $display("FAIL rst_ps: got %0d want 0", a_ps); end
    n_cmp++; if (a_pwm !== 1'b0) begin n_err++; $display("FAIL rst_pwm_a: got %0d want 0", a_pwm); end
    n_cmp++; if (b_pwm !== 1'b1) begin n_err++; $display("FAIL rst_pwm_b: got %0d want 1", b_pwm); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int hi, hi_first, ps_n, first, last;
    a_duty_in = 8'd128; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    n_cmp++; if (a_duty_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_full: got %0d want 0", a_duty_ready); end
    n_cmp++; if (a_duty_active !== 8'd0) begin n_err++; $display("FAIL basic_idle_duty: got %0d want 0", a_duty_active); end
    a_enable = 1'b1;
    step();
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL basic_ps_start: got %0d want 1", a_ps); end
    n_cmp++; if (a_duty_active !== 8'd128) begin n_err++; $display("FAIL basic_load: got %0d want 128", a_duty_active); end
    n_cmp++; if (a_duty_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_free: got %0d want 1", a_duty_ready); end
    hi = 0; hi_first = 0; ps_n = 0; first = 0; last = 0;
    for (int i = 1; i <= 510; i++) begin
      step();
      if (i <= 255 && a_pwm) hi++;
      if (i <= 128 && a_pwm) hi_first++;
      if (a_ps) begin
        ps_n++;
        if (ps_n == 1) first = i;
        last = i;
      end
    end
    n_cmp++; if (hi !== 128) begin n_err++; $display("FAIL basic_high_cnt: got %0d want 128", hi); end
    n_cmp++; if (hi_first !== 128) begin n_err++; $display("FAIL basic_high_first: got %0d want 128", hi_first); end
    n_cmp++; if (ps_n !== 2) begin n_err++; $display("FAIL basic_ps_cnt: got %0d want 2", ps_n); end
    n_cmp++; if (first !== 255) begin n_err++; $display("FAIL basic_ps_first: got %0d want 255", first); end
    n_cmp++; if (last !== 510) begin n_err++; $display("FAIL basic_ps_last: got %0d want 510", last); end
  endtask

  task automatic test_extremes();
    int n, hi;
    a_duty_in = 8'd0; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    wait_ps_a(n);
    n_cmp++; if (n !== 254) begin n_err++; $display("FAIL ext_wait0: got %0d want 254", n); end
    n_cmp++; if (a_duty_active !== 8'd0) begin n_err++; $display("FAIL ext_duty0: got %0d want 0", a_duty_active); end
    a_duty_in = 8'd255; a_duty_valid = 1'b1;
    hi = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (i == 1) a_duty_valid = 1'b0;
      if (a_pwm) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_err++; $display("FAIL ext_zero_high: got %0d want 0", hi); end
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL ext_ps1: got %0d want 1", a_ps); end
    n_cmp++; if (a_duty_active !== 8'd255) begin n_err++; $display("FAIL ext_duty255: got %0d want 255", a_duty_active); end
    hi = 0;
    for (int i = 1; i <= 255; i++) begin
      step();
      if (a_pwm) hi++;
    end
    n_cmp++; if (hi !== 255) begin n_err++; $display("FAIL ext_full_high: got %0d want 255", hi); end
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL ext_ps2: got %0d want 1", a_ps); end
  endtask

  task automatic test_update();
    int n, bad;
    a_duty_in = 8'd200; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    wait_ps_a(n);
    n_cmp++; if (a_duty_active !== 8'd200) begin n_err++; $display("FAIL upd_duty200: got %0d want 200", a_duty_active); end
    step_n(50);
    a_duty_in = 8'd64; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    n_cmp++; if (a_duty_ready !== 1'b0) begin n_err++; $display("FAIL upd_ready_low: got %0d want 0", a_duty_ready); end
    n_cmp++; if (a_duty_active !== 8'd200) begin n_err++; $display("FAIL upd_hold200: got %0d want 200", a_duty_active); end
    bad = 0; n = 0;
    while (n < 300) begin
      step();
      n++;
      if (a_ps) break;
      if (a_duty_ready !== 1'b0 || a_duty_active !== 8'd200) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL upd_pending: got %0d want 0 bad cycles", bad); end
    n_cmp++; if (n !== 204) begin n_err++; $display("FAIL upd_wait: got %0d want 204", n); end
    n_cmp++; if (a_duty_active !== 8'd64) begin n_err++; $display("FAIL upd_duty64: got %0d want 64", a_duty_active); end
    n_cmp++; if (a_duty_ready !== 1'b1) begin n_err++; $display("FAIL upd_ready_back: got %0d want 1", a_duty_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    a_duty_in = 8'd10; a_duty_valid = 1'b1;
    step();
    a_duty_in = 8'd20;
    n_cmp++; if (a_duty_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_low: got %0d want 0", a_duty_ready); end
    n = 0;
    while (!a_duty_ready && n < 300) begin
      step();
      n++;
    end
    n_cmp++; if (n !== 254) begin n_err++; $display("FAIL b2b_holdoff: got %0d want 254", n); end
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL b2b_ps: got %0d want 1", a_ps); end
    n_cmp++; if (a_duty_active !== 8'd10) begin n_err++; $display("FAIL b2b_duty10: got %0d want 10", a_duty_active); end
    step();
    a_duty_valid = 1'b0;
    n_cmp++; if (a_duty_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept20: got %0d want 0", a_duty_ready); end
    wait_ps_a(n);
    n_cmp++; if (n !== 254) begin n_err++; $display("FAIL b2b_wait20: got %0d want 254", n); end
    n_cmp++; if (a_duty_active !== 8'd20) begin n_err++; $display("FAIL b2b_duty20: got %0d want 20", a_duty_active); end
    // Accept exactly on the boundary edge with an empty shadow: no bypass.
    step_n(254);
    a_duty_in = 8'd30; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL sim_ps: got %0d want 1", a_ps); end
    n_cmp++; if (a_duty_active !== 8'd20) begin n_err++; $display("FAIL sim_no_bypass: got %0d want 20", a_duty_active); end
    n_cmp++; if (a_duty_ready !== 1'b0) begin n_err++; $display("FAIL sim_ready: got %0d want 0", a_duty_ready); end
    wait_ps_a(n);
    n_cmp++; if (n !== 255) begin n_err++; $display("FAIL sim_wait: got %0d want 255", n); end
    n_cmp++; if (a_duty_active !== 8'd30) begin n_err++; $display("FAIL sim_duty30: got %0d want 30", a_duty_active); end
  endtask

  task automatic test_enable();
    int n;
    a_duty_in = 8'd200; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    wait_ps_a(n);
    step_n(100);
    n_cmp++; if (a_pwm !== 1'b1) begin n_err++; $display("FAIL en_pwm_run: got %0d want 1", a_pwm); end
    a_enable = 1'b0;
    step();
    n_cmp++; if (a_pwm !== 1'b0) begin n_err++; $display("FAIL en_pwm_idle: got %0d want 0", a_pwm); end
    n_cmp++; if (a_ps !== 1'b0) begin n_err++; $display("FAIL en_ps_idle: got %0d want 0", a_ps); end
    step_n(3);
    n_cmp++; if (a_pwm !== 1'b0) begin n_err++; $display("FAIL en_pwm_idle2: got %0d want 0", a_pwm); end
    n_cmp++; if (a_duty_active !== 8'd200) begin n_err++; $display("FAIL en_retain: got %0d want 200", a_duty_active); end
    a_enable = 1'b1;
    step();
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL en_restart_ps: got %0d want 1", a_ps); end
    wait_ps_a(n);
    n_cmp++; if (n !== 255) begin n_err++; $display("FAIL en_restart_period: got %0d want 255", n); end
    // Drop enable on the boundary cycle with a full shadow.
    a_duty_in = 8'd40; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    step_n(253);
    a_enable = 1'b0;
    step();
    n_cmp++; if (a_ps !== 1'b0) begin n_err++; $display("FAIL en_bnd_ps: got %0d want 0", a_ps); end
    n_cmp++; if (a_duty_active !== 8'd200) begin n_err++; $display("FAIL en_bnd_noload: got %0d want 200", a_duty_active); end
    n_cmp++; if (a_duty_ready !== 1'b0) begin n_err++; $display("FAIL en_bnd_ready: got %0d want 0", a_duty_ready); end
    a_enable = 1'b1;
    step();
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL en_reload_ps: got %0d want 1", a_ps); end
    n_cmp++; if (a_duty_active !== 8'd40) begin n_err++; $display("FAIL en_reload_duty: got %0d want 40", a_duty_active); end
  endtask

  task automatic test_reset_mid();
    step_n(5);
    n_cmp++; if (a_pwm !== 1'b1) begin n_err++; $display("FAIL rmid_pwm_pre: got %0d want 1", a_pwm); end
    a_duty_in = 8'd77; a_duty_valid = 1'b1;
    step();
    a_duty_valid = 1'b0;
    n_cmp++; if (a_duty_ready !== 1'b0) begin n_err++; $display("FAIL rmid_pending: got %0d want 0", a_duty_ready); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (a_duty_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %0d want 1", a_duty_ready); end
    n_cmp++; if (a_duty_active !== 8'd0) begin n_err++; $display("FAIL rmid_duty: got %0d want 0", a_duty_active); end
    n_cmp++; if (a_pwm !== 1'b0) begin n_err++; $display("FAIL rmid_pwm: got %0d want 0", a_pwm); end
    n_cmp++; if (a_ps !== 1'b0) begin n_err++; $display("FAIL rmid_ps: got %0d want 0", a_ps); end
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (a_ps !== 1'b1) begin n_err++; $display("FAIL rmid_restart_ps: got %0d want 1", a_ps); end
    n_cmp++; if (a_duty_active !== 8'd0) begin n_err++; $display("FAIL rmid_lost: got %0d want 0", a_duty_active); end
    a_enable = 1'b0;
    step();
  endtask

  task automatic test_prescale();
    int lo, lo_first, first;
    n_cmp++; if (b_pwm !== 1'b1) begin n_err++; $display("FAIL pre_idle_pwm: got %0d want 1", b_pwm); end
    b_duty_in = 8'd3; b_duty_valid = 1'b1;
    step();
    b_duty_valid = 1'b0;
    b_enable = 1'b1;
    step();
    n_cmp++; if (b_ps !== 1'b1) begin n_err++; $display("FAIL pre_ps_start: got %0d want 1", b_ps); end
    n_cmp++; if (b_duty_active !== 8'd3) begin n_err++; $display("FAIL pre_duty: got %0d want 3", b_duty_active); end
    lo = 0; lo_first = 0; first = 0;
    for (int i = 1; i <= 1020; i++) begin
      step();
      if (!b_pwm) lo++;
      if (i <= 12 && !b_pwm) lo_first++;
      if (b_ps && first == 0) first = i;
    end
    n_cmp++; if (lo !== 12) begin n_err++; $display("FAIL pre_low_cnt: got %0d want 12", lo); end
    n_cmp++; if (lo_first !== 12) begin n_err++; $display("FAIL pre_low_first: got %0d want 12", lo_first); end
    n_cmp++; if (first !== 1020) begin n_err++; $display("FAIL pre_period: got %0d want 1020", first); end
    b_enable = 1'b0;
    step();
    n_cmp++; if (b_pwm !== 1'b1) begin n_err++; $display("FAIL pre_idle_after: got %0d want 1", b_pwm); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    a_duty_in = '0; a_duty_valid = 1'b0; a_enable = 1'b0;
    b_duty_in = '0; b_duty_valid = 1'b0; b_enable = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_update();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_encoder.md
Name: pwm_encoder

Overview:
- Converts an 8-bit duty value, such as the breathing-ramp R_time_out, into a PWM waveform on one pin.
- Duty values arrive over a valid/ready handshake into a shadow register.
- The shadow value becomes active only at a period boundary, so the waveform never glitches mid-period.
- Sits between the duty-ramp generator and the LED/output pin.

Parameters:
- WIDTH, 8: duty and period counter width; one PWM period = 2^WIDTH-1 ticks.
- PRESCALE, 1: clk cycles per tick; legal range 1 to 2^16.
- POLARITY, 0: 0 = active-high output; 1 = pwm_out inverted (idle level is then high).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- duty_in  input  WIDTH  new duty value, high ticks per period.
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  shadow register is empty and can accept a value.
- enable  input  1  1 = run PWM; 0 = idle.
- pwm_out  output  1  registered PWM waveform.
- period_start  output  1  one-cycle pulse in the cycle pcnt is 0 at the start of each period.
- duty_active  output  WIDTH  duty value governing the current period.

Behaviour:
- Reset is asynchronous (rst high) and sets:
  - state=IDLE, pre_cnt=0, pcnt=0;
  - shadow=0, shadow_full=0, duty_ready=1;
  - duty_active=0, period_start=0, pwm_out=POLARITY.
- Handshake:
  - duty_ready = !shadow_full (combinational from the register).
  - Accept when duty_valid && duty_ready: shadow<=duty_in, shadow_full<=1.
  - duty_valid while not ready is ignored; the sender holds the value.
- States:
  - IDLE:
    - pre_cnt=0, pcnt=0, pwm_out<=POLARITY, period_start<=0.
    - If enable=1: next state RUN, pcnt<=0, pre_cnt<=0, period_start<=1.
    - On that same transition, if shadow_full: duty_active<=shadow, shadow_full<=0.
  - RUN:
    - If enable=0: next state IDLE; counters cleared; pwm_out<=POLARITY the next cycle.
    - On leaving RUN, shadow and duty_active are retained.
- Prescaler (RUN only):
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick = (pre_cnt==PRESCALE-1). With PRESCALE=1, tick is every cycle.
- Period counter:
  - On tick, pcnt increments. At pcnt==2^WIDTH-2 it wraps to 0 instead.
  - The wrap is a boundary: period_start<=1.
  - At a boundary, if shadow_full: duty_active<=shadow, shadow_full<=0.
  - Period = (2^WIDTH-1)*PRESCALE clk cycles.
- Output:
  - In RUN, pwm_out <= (pcnt < duty_active) XOR POLARITY.
  - pwm_out lags pcnt/duty_active by one cycle.
  - duty=0 gives a constant inactive level.
  - duty=2^WIDTH-1 gives a constant active level; both are exact, no spurious edges.
- Simultaneous events:
  - Accept in the same cycle as a boundary with the shadow empty:
    - the boundary finds nothing to load, so duty_active is unchanged;
    - the accepted value loads at the following boundary (no bypass).
  - Boundary in the same cycle as a shadow-full cycle:
    - the load happens and duty_ready rises the next cycle;
    - no accept is possible in the load cycle.
  - enable falling on a boundary cycle: IDLE wins; no load, no period_start.
- Reset mid-operation: immediate return to reset values; any pending shadow value is discarded.
- Arithmetic: comparisons are unsigned. Counter wrap widths are exact; no overflow past 2^WIDTH-2.

Test Plan:
- PRESCALE=1:
  - stimulus: write 128, then enable.
  - response: period_start every 255 cycles; pwm_out high 128 cycles, low 127; duty_active=128.
- duty 0 then 255, each applied at a boundary -> pwm_out constant 0 for a full period, then constant 1; no edges inside either period.
- Update while running with duty 200:
  - stimulus: write 64 at pcnt=50.
  - response: duty_active stays 200 until the next period_start, then 64; duty_ready is 0 between accept and load.
- Back-pressure:
  - stimulus: two back-to-back writes 10 then 20.
  - response: 10 accepted; duty_ready=0 holds 20 off until the boundary loads 10; 20 is then accepted and loads one period later.
- PRESCALE=4, POLARITY=1, duty 3:
  - response: period 1020 cycles; pwm_out low 12 cycles, high 1008; in IDLE, pwm_out=1.
- enable dropped at pcnt=100 -> pwm_out=POLARITY next cycle; re-enable gives period_start with pcnt=0.
- rst asserted mid-period:
  - stimulus: rst with a pending shadow write.
  - response: all outputs at reset values asynchronously; the shadow write is lost; duty_ready=1.
